alu_fdiv: RTL and testbench
===========================

// Module: alu_fdiv
// PURPOSE
//  Multi-cycle signed fractional divider, the inverse of the ALU fractional multiply.
//  The ALU computes (a*b)>>FRAC; this block computes (a<<FRAC)/b in the same Q1.FRAC format.
//  It sits beside the ALU as a co-processor, driven by the controller through a start/done handshake.
//  Uses radix-2 restoring division, one quotient bit per clock, so the area stays near the ALU's.
// PARAMETERS
//  N     8  operand/result width, two's complement
//  FRAC  7  fractional bits; numerator is a shifted left by FRAC
// PORTS
//  clk     in   1  single clock, rising edge
//  reset   in   1  asynchronous, active-high; clears all state
//  start   in   1  request; sampled only in IDLE
//  a       in   N  signed dividend, Q1.FRAC
//  b       in   N  signed divisor, Q1.FRAC
//  busy    out  1  high while in CALC or FIX
//  done    out  1  one-cycle pulse; result/ovf/dz valid from this cycle
//  result  out  N  signed quotient, Q1.FRAC, held until the next done
//  ovf     out  1  quotient saturated; held with result
//  dz      out  1  divisor was zero; held with result
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is asynchronous, active-high.
//  Reset values: state=IDLE, busy=0, done=0, result=0, ovf=0, dz=0, internal regs=0.
//  W = N+FRAC (15 by default). Iteration counter is ceil(log2 W) bits wide.
//  FSM states IDLE, CALC, FIX:
//  - IDLE -> CALC on start.
//    - latch sa=sign(a), sb=sign(b), dz=(b==0).
//    - num=|a|<<FRAC (W bits; |-2^(N-1)|=2^(N-1) fits), den=|b| (N bits).
//    - rem=0, cnt=W-1.
//  - CALC, one edge per bit:
//    - rem={rem,num[MSB]}, num<<=1.
//    - If rem>=den: rem-=den, qbit=1; else qbit=0. qbit shifts into the LSB of q.
//    - cnt==0 -> FIX, else cnt--.
//    - rem is N+1 bits wide.
//  - FIX (1 cycle) -> IDLE.
//    - Write result/ovf/dz and assert done for exactly one cycle.
//  Latency: start sampled at edge k -> done=1 in the cycle after edge k+W+1 (16 cycles by default).
//  Latency is fixed and independent of the data, including divide-by-zero.
//  busy=1 from edge k+1 until the edge that asserts done. done and busy are never high together.
//  Arithmetic: |q| truncates toward zero (quotient of magnitudes). Sign neg = sa^sb.
//  Saturation:
//  - neg=0: q>2^(N-1)-1 -> result=+max (0x7F), ovf=1; else result=q.
//  - neg=1: q>2^(N-1) -> result=-2^(N-1) (0x80), ovf=1; else result=-q (q=0 gives 0).
//  Divide by zero: dz=1, ovf=0. result=+max if a>=0, -2^(N-1) if a<0. Do not rely on restoring-loop artefacts.
//  Operands are captured at start; changes to a/b during busy have no effect.
//  start while busy is ignored and not queued.
//  start in the cycle done=1 is accepted (state is IDLE), giving back-to-back operations.
//  Reset mid-operation aborts immediately to IDLE with all outputs 0. No done is produced for the aborted op.
//  A start held high continuously re-launches each time IDLE is reached.
// TESTING
//  1 a=0x40(0.5), b=0x60(0.75), start pulse -> 16 cycles later done=1, result=0x55, ovf=0, dz=0.
//  2 a=0xC0(-0.5), b=0x60 -> result=0xAB(-85). a=0xC0, b=0xA0 -> result=0x55. a=0, b=0x40 -> result=0x00.
//  3 Overflow:
//    - a=0x60, b=0x40 -> 0x7F, ovf=1.
//    - a=0x80, b=0x80 -> 0x7F, ovf=1.
//    - a=0x80, b=0x7F -> 0x80, ovf=1.
//    - a=0x40, b=0x80 -> 0xC0, ovf=0.
//  4 Divide by zero: a=0x05, b=0 -> 0x7F, dz=1, ovf=0. a=0xFB, b=0 -> 0x80, dz=1. Latency still 16.
//  5 Handshake:
//    - start at cycle 3 of busy with new operands -> ignored; first result unchanged, exactly one done.
//    - start coincident with done -> second done 16 cycles later.
//    - a/b toggled during busy -> result unchanged.
//  6 Reset asserted asynchronously mid-CALC (between edges) -> outputs 0 immediately, no done.
//    New start after reset release -> correct result with normal latency.

Source files
------------

// File: rtl/alu_fdiv.sv
// Signed Q1.FRAC fractional divider, (a<<FRAC)/b, radix-2 restoring, one quotient bit per clock.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+N+FRAC+1 (16 cycles at N=8).
// Backpressure: none; start is honoured only in IDLE, and a start while busy is dropped, not queued.
module alu_fdiv #(
  parameter int N    = 8,
  parameter int FRAC = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         dz
);

  // Quotient width covers the full numerator, so the loop never loses high bits.
  localparam int W  = N + FRAC;
  localparam int CW = $clog2(W);

  // Saturation limits on the magnitude of the quotient.
  localparam int            POSMAX  = 2**(N-1) - 1;
  localparam logic [W-1:0]  POS_LIM = POSMAX[W-1:0];
  localparam logic [W-1:0]  NEG_LIM = POS_LIM + 1'b1;
  localparam logic [N-1:0]  MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  // Operands and loop state captured at start.
  logic           sa;
  logic           sb;
  logic           dz_lat;
  logic [W-1:0]   num;
  logic [N-1:0]   den;
  logic [N:0]     rem;
  logic [W-1:0]   q;
  logic [CW-1:0]  cnt;

  // FSM-decoded controls.
  logic           load;
  logic           step;
  logic           fin;

  // Magnitudes of the inputs; |-2^(N-1)| = 2^(N-1) still fits as an unsigned N-bit value.
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  assign a_mag = a[N-1] ? (~a + 1'b1) : a;
  assign b_mag = b[N-1] ? (~b + 1'b1) : b;

  // One restoring step: remainder takes the next numerator bit, then trial-subtracts the divisor.
  logic [N:0]     rem_sh;
  logic [N:0]     rem_dif;
  logic           qbit;
  assign rem_sh  = {rem[N-1:0], num[W-1]};
  assign rem_dif = rem_sh - {1'b0, den};
  assign qbit    = (rem_sh >= {1'b0, den});

  // Final signed, saturated result computed from the magnitude quotient during FIX.
  logic           neg;
  logic [N-1:0]   q_neg;
  logic [N-1:0]   res_nxt;
  logic           ovf_nxt;
  assign neg   = sa ^ sb;
  assign q_neg = ~q[N-1:0] + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed W iterations regardless of data, then one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and datapath controls.
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    case (state)
      IDLE:    load = start;
      CALC:    begin busy = 1'b1; step = 1'b1; end
      FIX:     begin busy = 1'b1; fin  = 1'b1; end
      default: ;
    endcase
  end

  // Sign/saturation fix-up; divide-by-zero uses only the dividend sign, not loop artefacts.
  always_comb begin
    res_nxt = '0;
    ovf_nxt = 1'b0;
    if (dz_lat) begin
      res_nxt = sa ? MIN_NEG : MAX_POS;
      ovf_nxt = 1'b0;
    end else if (!neg) begin
      if (q > POS_LIM) begin
        res_nxt = MAX_POS;
        ovf_nxt = 1'b1;
      end else begin
        res_nxt = q[N-1:0];
      end
    end else begin
      if (q > NEG_LIM) begin
        res_nxt = MIN_NEG;
        ovf_nxt = 1'b1;
      end else begin
        res_nxt = q_neg;
      end
    end
  end

  // Datapath: capture at start, iterate in CALC, publish and pulse done on leaving FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz_lat <= 1'b0;
      num    <= '0;
      den    <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        sa     <= a[N-1];
        sb     <= b[N-1];
        dz_lat <= (b == '0);
        num    <= {a_mag, {FRAC{1'b0}}};
        den    <= b_mag;
        rem    <= '0;
        q      <= '0;
        cnt    <= CW'(W - 1);
      end else if (step) begin
        num <= {num[W-2:0], 1'b0};
        rem <= qbit ? rem_dif : rem_sh;
        q   <= {q[W-2:0], qbit};
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (fin) begin
        result <= res_nxt;
        ovf    <= ovf_nxt;
        dz     <= dz_lat;
      end
    end
  end

endmodule

// File: tb/tb_alu_fdiv.sv
// Directed bench for alu_fdiv: arithmetic vectors, saturation, divide-by-zero, handshake and reset abort.
// Every run checks done latency plus result/ovf/dz against hand-computed values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_alu_fdiv;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       ovf;
  logic       dz;

  int tests;
  int fails;

  alu_fdiv #(.N(8), .FRAC(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .dz     (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and pulse start for the next edge (edge k).
  task automatic launch(input logic [7:0] aa, input logic [7:0] bb);
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after edge k until done is seen; 999 on timeout.
  task automatic wait_done(output int n);
    int  i;
    bit  seen;
    seen = 0;
    i    = 0;
    while (i < 40 && !seen) begin
      @(posedge clk); #1;
      i++;
      if (done) seen = 1;
    end
    n = seen ? i : 999;
  endtask

  task automatic run_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] er, input logic eo, input logic ed);
    int n;
    launch(aa, bb);
    wait_done(n);
    check({tag, ".lat"}, n, 16);
    check({tag, ".res"}, result, er);
    check({tag, ".ovf"}, ovf, eo);
    check({tag, ".dz"},  dz, ed);
  endtask

  // Directed vectors: a, b, expected result, ovf, dz.
  logic [7:0] va [10];
  logic [7:0] vb [10];
  logic [7:0] vr [10];
  logic       vo [10];
  logic       vd [10];

  initial begin
    int n;
    int ndone;
    int lat;
    logic [7:0] res0;

    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    va = '{8'h40, 8'hC0, 8'hC0, 8'h00, 8'h60, 8'h80, 8'h80, 8'h40, 8'h05, 8'hFB};
    vb = '{8'h60, 8'h60, 8'hA0, 8'h40, 8'h40, 8'h80, 8'h7F, 8'h80, 8'h00, 8'h00};
    vr = '{8'h55, 8'hAB, 8'h55, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'hC0, 8'h7F, 8'h80};
    vo = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    vd = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.res",  result, 0);
    check("rst.ovf",  ovf, 0);
    check("rst.dz",   dz, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Arithmetic, saturation and divide-by-zero vectors.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), va[i], vb[i], vr[i], vo[i], vd[i]);
      check($sformatf("vec%0d.busy", i), busy, 0);
    end

    // Start during busy is ignored; operand changes during busy have no effect.
    launch(8'h40, 8'h60);
    ndone = 0;
    lat   = 999;
    res0  = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i >= 3 && i <= 14) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      start = (i == 3);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat  = i;
          res0 = result;
        end
      end
    end
    start = 1'b0;
    check("busy_start.ndone", ndone, 1);
    check("busy_start.lat",   lat, 16);
    check("busy_start.res",   res0, 8'h55);

    // Back-to-back: start coincident with done is accepted.
    launch(8'h40, 8'h60);
    wait_done(n);
    check("b2b.lat1", n, 16);
    check("b2b.res1", result, 8'h55);
    launch(8'hC0, 8'h60);
    wait_done(n);
    check("b2b.lat2", n, 16);
    check("b2b.res2", result, 8'hAB);

    // Asynchronous reset mid-CALC clears outputs immediately and suppresses done.
    launch(8'h60, 8'h40);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst.busy", busy, 0);
    check("arst.res",  result, 0);
    check("arst.ovf",  ovf, 0);
    check("arst.done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("arst.nodone", ndone, 0);
    run_op("post_rst", 8'hC0, 8'h60, 8'hAB, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
